decoder_scan_ctrl: RTL

DECODER_SCAN_CTRL -- requirements
Module: decoder_scan_ctrl

---
 rtl/decoder_scan_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: timed channel scan for a 3-to-8 decoder with blanking gaps.
// Define SCAN_MASK_EN to add chan_mask and skip disabled channels.
module decoder_scan_ctrl #(
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
`ifdef SCAN_MASK_EN
    input  logic [7:0] chan_mask,
`endif
    output logic       A0,
    output logic       A1,
    output logic       A2,
    output logic       E1_n,
    output logic       E2_n,
    output logic       E3,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        ACTIVE
    } state_e;

    localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);
    localparam logic [7:0]  BLANK_LAST = 8'(BLANK_CYCLES - 1);

    state_e      state_q;
    logic [2:0]  addr_q;
    logic [15:0] dwell_q;
    logic [7:0]  blank_q;
    logic        stop_q;
    logic        en_q;
    logic        done_q;

    logic [7:0]  mask;
    logic [2:0]  first_ch;
    logic [2:0]  next_ch;
    logic        any_en;
    logic        wrap;
    logic        stop_pend;

`ifdef SCAN_MASK_EN
    assign mask = chan_mask;
`else
    assign mask = 8'hFF;
`endif

    assign any_en    = |mask;
    assign stop_pend = stop_q | stop;
    assign wrap      = (next_ch <= addr_q);

    // Lowest set bit, and first set bit strictly after addr_q (wrapping).
    always_comb begin
        first_ch = '0;
        next_ch  = addr_q;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) first_ch = 3'(i);
        end
        for (int k = 8; k >= 1; k--) begin
            if (mask[3'(addr_q + 3'(k))]) next_ch = 3'(addr_q + 3'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            dwell_q <= '0;
            blank_q <= '0;
            stop_q  <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start && !stop && any_en) begin
                        state_q <= BLANK;
                        addr_q  <= first_ch;
                        blank_q <= '0;
                    end
                end
                BLANK: begin
                    if (stop_pend) begin
                        state_q <= IDLE;
                        stop_q  <= 1'b0;
                    end else if (blank_q == BLANK_LAST) begin
                        state_q <= ACTIVE;
                        en_q    <= 1'b1;
                        dwell_q <= '0;
                    end else begin
                        blank_q <= blank_q + 8'd1;
                    end
                end
                ACTIVE: begin
                    if (dwell_q == DWELL_LAST) begin
                        en_q   <= 1'b0;
                        done_q <= wrap && any_en;
                        // Address only moves here, so it is stable while enabled.
                        if (stop_pend || !any_en) begin
                            state_q <= IDLE;
                            stop_q  <= 1'b0;
                        end else begin
                            state_q <= BLANK;
                            addr_q  <= next_ch;
                            blank_q <= '0;
                        end
                    end else begin
                        dwell_q <= dwell_q + 16'd1;
                        if (stop) stop_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

    assign {A2, A1, A0} = addr_q;
    assign E1_n         = ~en_q;
    assign E2_n         = ~en_q;
    assign E3           = en_q;
    assign busy         = (state_q != IDLE);
    assign frame_done   = done_q;

endmodule
